// File: rtl/nand_logic_serial.sv
// Bit-serial two-operand logic unit: evaluates one of eight NAND-built functions
// over WIDTH-bit operands, LANES bits per clock, with a start/busy/done handshake.
module nand_logic_serial #(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    localparam int N  = WIDTH / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 1 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_params
            $error("nand_logic_serial: LANES must divide WIDTH and WIDTH must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r, res_r, res_nxt;
    logic [2:0]       op_r;
    logic [CW-1:0]    cnt;
    logic [LANES-1:0] sa, sb, lane_y;
    logic [LANES-1:0] na, nb, nab, t_and, t_or, t_nor, t_xor, t_xnor, t_pass;
    logic             accept;
    int unsigned      base;

    function automatic logic [LANES-1:0] nand2(input logic [LANES-1:0] x, input logic [LANES-1:0] z);
        return ~(x & z);
    endfunction

    assign accept = start && (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane network: every function is composed solely of 2-input NANDs.
    always_comb begin
        base    = int'(cnt) * LANES;
        sa      = a_r[base +: LANES];
        sb      = b_r[base +: LANES];
        na      = nand2(sa, sa);
        nb      = nand2(sb, sb);
        nab     = nand2(sa, sb);
        t_and   = nand2(nab, nab);
        t_or    = nand2(na, nb);
        t_nor   = nand2(t_or, t_or);
        t_xor   = nand2(nand2(sa, nab), nand2(sb, nab));
        t_xnor  = nand2(t_xor, t_xor);
        t_pass  = nand2(na, na);
        case (op_r)
            3'd0:    lane_y = nab;
            3'd1:    lane_y = t_nor;
            3'd2:    lane_y = t_and;
            3'd3:    lane_y = t_or;
            3'd4:    lane_y = t_xor;
            3'd5:    lane_y = t_xnor;
            3'd6:    lane_y = na;
            default: lane_y = t_pass;
        endcase
        res_nxt = res_r;
        res_nxt[base +: LANES] = lane_y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            op_r  <= '0;
            cnt   <= '0;
            res_r <= '0;
            y     <= '0;
            zero  <= 1'b0;
        end else if (accept) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= op;
            cnt  <= '0;
        end else if (state == RUN) begin
            res_r <= res_nxt;
            cnt   <= cnt + CW'(1);
            // y is published only once the final slice is merged in.
            if (cnt == LAST) begin
                y    <= res_nxt;
                zero <= (res_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_nand_logic_serial.sv
// Self-checking bench for nand_logic_serial at (8,1), (8,4) and (2,1) configurations.
module tb_nand_logic_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start8 = 1'b0, start4 = 1'b0, start2 = 1'b0;
    logic [2:0] op = '0;
    logic [7:0] a = '0, b = '0;
    logic [1:0] a2 = '0, b2 = '0;

    logic       busy8, done8, zero8, busy4, done4, zero4, busy2, done2, zero2;
    logic [7:0] y8, y4;
    logic [1:0] y2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nand_logic_serial #(.WIDTH(8), .LANES(1)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op), .a(a), .b(b),
        .busy(busy8), .done(done8), .y(y8), .zero(zero8));

    nand_logic_serial #(.WIDTH(8), .LANES(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op(op), .a(a), .b(b),
        .busy(busy4), .done(done4), .y(y4), .zero(zero4));

    nand_logic_serial #(.WIDTH(2), .LANES(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .y(y2), .zero(zero2));

    typedef struct {
        int         s;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       z;
        int         n;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x,
                                          input logic [7:0] z, input int w);
        logic [7:0] r;
        case (o)
            3'd0:    r = ~(x & z);
            3'd1:    r = ~(x | z);
            3'd2:    r = x & z;
            3'd3:    r = x | z;
            3'd4:    r = x ^ z;
            3'd5:    r = ~(x ^ z);
            3'd6:    r = ~x;
            default: r = x;
        endcase
        return r & 8'((1 << w) - 1);
    endfunction

    function automatic logic dn(input int s);
        return (s == 0) ? done8 : (s == 1) ? done4 : done2;
    endfunction

    function automatic logic bz(input int s);
        return (s == 0) ? busy8 : (s == 1) ? busy4 : busy2;
    endfunction

    function automatic logic [7:0] yv(input int s);
        return (s == 0) ? y8 : (s == 1) ? y4 : {6'b0, y2};
    endfunction

    function automatic logic zr(input int s);
        return (s == 0) ? zero8 : (s == 1) ? zero4 : zero2;
    endfunction

    task automatic set_start(input int s, input logic v);
        if (s == 0) start8 = v;
        else if (s == 1) start4 = v;
        else start2 = v;
    endtask

    // One start pulse, then count edges to done; inputs are scrambled during RUN.
    task automatic run_op(input int s, input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                          output logic [7:0] yo, output logic zo, output int lat);
        logic [7:0] yprev;
        logic       busy_ok, hold_ok;
        @(negedge clk);
        op = o;
        if (s == 2) begin a2 = av[1:0]; b2 = bv[1:0]; end
        else begin a = av; b = bv; end
        set_start(s, 1'b1);
        yprev = yv(s);
        @(negedge clk);
        set_start(s, 1'b0);
        op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
        a2 = 2'($urandom); b2 = 2'($urandom);
        lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
        while (!dn(s) && lat < 40) begin
            if (!bz(s)) busy_ok = 1'b0;
            if (yv(s) !== yprev) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        yo = yv(s);
        zo = zr(s);
        check("busy_during_run", 32'(busy_ok), 32'd1);
        check("y_hold_during_run", 32'(hold_ok), 32'd1);
        check("busy_low_at_done", 32'(bz(s)), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(dn(s)), 32'd0);
    endtask

    vec_t       vecs[$];
    logic [7:0] ry, ea, eb;
    logic       rz, saw_done;
    logic [2:0] eo;
    int         rlat, last_done, n_done;

    initial begin
        vecs.push_back('{0, 3'd0, 8'hF0, 8'hCC, 8'h3F, 1'b0, 8});
        vecs.push_back('{0, 3'd1, 8'hF0, 8'hCC, 8'h03, 1'b0, 8});
        vecs.push_back('{0, 3'd3, 8'hF0, 8'hCC, 8'hFC, 1'b0, 8});
        vecs.push_back('{1, 3'd4, 8'hF0, 8'hCC, 8'h3C, 1'b0, 2});
        vecs.push_back('{1, 3'd2, 8'hF0, 8'h0F, 8'h00, 1'b1, 2});
        vecs.push_back('{0, 3'd5, 8'hF0, 8'hCC, 8'hC3, 1'b0, 8});
        vecs.push_back('{0, 3'd6, 8'h5A, 8'h00, 8'hA5, 1'b0, 8});
        vecs.push_back('{1, 3'd7, 8'h5A, 8'hFF, 8'h5A, 1'b0, 2});
        vecs.push_back('{0, 3'd2, 8'hF0, 8'h0F, 8'h00, 1'b1, 8});

        #1 rst_n = 1'b0;
        #2;
        check("reset_busy", 32'(busy8), 32'd0);
        check("reset_done", 32'(done8), 32'd0);
        check("reset_y", 32'(y8), 32'd0);
        check("reset_zero", 32'(zero8), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].s, vecs[i].op, vecs[i].a, vecs[i].b, ry, rz, rlat);
            check($sformatf("vec%0d_y", i), 32'(ry), 32'(vecs[i].y));
            check($sformatf("vec%0d_zero", i), 32'(rz), 32'(vecs[i].z));
            check($sformatf("vec%0d_latency", i), 32'(rlat), 32'(vecs[i].n));
        end

        for (int o = 0; o < 8; o++)
            for (int x = 0; x < 4; x++)
                for (int z = 0; z < 4; z++) begin
                    run_op(2, 3'(o), 8'(x), 8'(z), ry, rz, rlat);
                    check($sformatf("w2_op%0d_a%0d_b%0d", o, x, z), 32'(ry), 32'(ref_op(3'(o), 8'(x), 8'(z), 2)));
                    check("w2_zero", 32'(rz), 32'(ref_op(3'(o), 8'(x), 8'(z), 2) == 8'h00));
                end

        for (int k = 0; k < 60; k++) begin
            int s;
            s  = k % 2;
            eo = 3'($urandom); ea = 8'($urandom); eb = 8'($urandom);
            run_op(s, eo, ea, eb, ry, rz, rlat);
            check("rand_y", 32'(ry), 32'(ref_op(eo, ea, eb, 8)));
            check("rand_zero", 32'(rz), 32'(ref_op(eo, ea, eb, 8) == 8'h00));
            check("rand_latency", 32'(rlat), (s == 0) ? 32'd8 : 32'd2);
        end

        // Back-to-back: start held high; a changes only while the op is running.
        @(negedge clk);
        op = 3'd6; a = 8'h5A; start8 = 1'b1;
        last_done = -1; n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done8) begin
                check("b2b_y", 32'(y8), 32'hA5);
                if (last_done >= 0) check("b2b_period", 32'(c - last_done), 32'd9);
                last_done = c;
                n_done++;
            end
            a = busy8 ? 8'($urandom) : 8'h5A;
        end
        check("b2b_count", 32'(n_done), 32'd4);
        start8 = 1'b0;
        for (int c = 0; c < 20 && (busy8 || done8); c++) @(negedge clk);

        // Reset in the middle of a run discards the operation at once.
        check("pre_reset_y_nonzero", 32'(y8 != 8'h00), 32'd1);
        op = 3'd0; a = 8'hF0; b = 8'hCC; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", 32'(busy8), 32'd0);
        check("midrun_reset_done", 32'(done8), 32'd0);
        check("midrun_reset_y", 32'(y8), 32'd0);
        check("midrun_reset_zero", 32'(zero8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) saw_done = 1'b1;
        end
        check("no_done_after_reset", 32'(saw_done), 32'd0);
        run_op(0, 3'd0, 8'hF0, 8'hCC, ry, rz, rlat);
        check("post_reset_y", 32'(ry), 32'h3F);
        check("post_reset_latency", 32'(rlat), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
